// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path (and a future receiver):
//   - tx_state_e    : transmitter state encoding (IDLE, START, DATA, PARITY, STOP)
//   - DEFAULT_CLOCK_FREQ / DEFAULT_BAUD_RATE : board defaults in Hz and bit/s
//   - cnt_width()   : width of a counter that runs 0..clks-1
// The PARITY state is only reachable when UART_TX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_CLOCK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD_RATE  = 115_200;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Bits needed to hold 0..clks-1; never narrower than one bit.
    function automatic int cnt_width(input int clks);
        return (clks < 2) ? 1 : $clog2(clks);
    endfunction

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Bit-time counter. Counts 0..CLKS_PER_BIT-1 while enabled and wraps to 0;
// bit_end_o is high in the cycle the counter sits at CLKS_PER_BIT-1.
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   enable_i   in   count this cycle
//   clear_i    in   force the counter to 0 (has priority over enable_i)
//   bit_end_o  out  last cycle of the current bit time
// -----------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic enable_i,
    input  logic clear_i,
    output logic bit_end_o
);

    localparam int              CNT_W   = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_end_o = enable_i && (cnt_q == CNT_MAX);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = bit_end_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : uart_baud_tick

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// 8N1/8N2 UART transmitter (optional parity bit). Accepts a byte on a one-cycle
// tx_start while idle and shifts it out LSB-first between a low start bit and
// STOP_BITS high stop bits. All outputs are registered and change only on
// bit-time boundaries.
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the data
// bits; PARITY_ODD then selects odd (1) or even (0) parity.
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset; aborts any frame at once
//   tx_start   in   one-cycle send request, ignored while busy
//   tx_data    in   byte to send, captured with an accepted tx_start
//   tx         out  serial line, idles high
//   uart_busy  out  high from the first start-bit cycle to the end of the frame
//   tx_done    out  one-cycle pulse as the last stop bit completes
// -----------------------------------------------------------------------------
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int STOP_BITS  = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       uart_busy,
    output logic       tx_done
);

    // Must come out >= 2; STOP_BITS must be 1 or 2.
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       bit_end;
`ifdef UART_TX_PARITY_EN
    // Parity is taken from the byte at acceptance; the shift register is
    // empty by the time the parity bit goes out.
    logic       parity_q, parity_d;
`endif

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clock     (clock),
        .reset     (reset),
        .enable_i  (state_q != ST_IDLE),
        .clear_i   (state_q == ST_IDLE),
        .bit_end_o (bit_end)
    );

    // Next-state and next-output logic. tx is registered, so each branch
    // sets the level the line takes in the following bit time.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    shift_d   = tx_data;
                    bit_idx_d = '0;
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d  = (^tx_data) ^ PARITY_ODD;
`endif
                end
            end

            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = ST_PARITY;
                        tx_d      = parity_q;
`else
                        state_d   = ST_STOP;
                        tx_d      = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                    tx_d      = 1'b1;
                end
            end
`endif

            ST_STOP: begin
                // bit_idx_q counts completed stop bits here.
                if (bit_end) begin
                    if (bit_idx_q == 3'(STOP_BITS - 1)) begin
                        state_d   = ST_IDLE;
                        bit_idx_d = '0;
                        tx_d      = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bit_idx_d = '0;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx        = tx_q;
    assign uart_busy = busy_q;
    assign tx_done   = done_q;

endmodule : uart_transmitter

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serial 8N1 UART transmit stage directly downstream of the game communication arbiter. Consumes the arbiter's tx_start/tx_data byte handshake, serialises each byte LSB-first onto the tx line, and returns uart_busy to the per-message senders so they pace their bytes. It is the only block driving the board's UART TX pin.

Parameters:
CLOCK_FREQ, 50000000, system clock frequency in Hz.
BAUD_RATE, 115200, line rate in bit/s.
CLKS_PER_BIT, CLOCK_FREQ/BAUD_RATE (434), clock cycles per bit. Derived localparam, must be >= 2.
STOP_BITS, 1, number of stop bits. Legal values are 1 or 2.

Ports:
clock  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
tx_start  input  1  one-cycle request to send tx_data; sampled only when the block is idle.
tx_data  input  8  byte to send; sampled in the cycle tx_start is accepted.
tx  output  1  serial line; idles high.
uart_busy  output  1  registered; high while a frame is in progress.
tx_done  output  1  registered one-cycle pulse when a frame's last stop bit completes.

Behaviour:
- Reset (reset=0, asynchronous): tx=1, uart_busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0, shift register=0. Reset mid-frame aborts the frame immediately. tx returns high with no stop bit.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: tx=1. If tx_start=1, latch tx_data into the shift register. Next cycle: state=START, tx=0, uart_busy=1. A 1-cycle accept latency.
- tx_start while uart_busy=1 is ignored; no queueing. Senders must wait for uart_busy=0.
- Baud counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state. A bit ends when the counter reaches CLKS_PER_BIT-1; the counter then wraps to 0.
- START: one bit time of tx=0, then go to DATA with bit index=0.
- DATA: tx = shift[0]. At each bit end, shift right and increment the bit index. After index 7 completes, go to PARITY (if enabled) or STOP.
- STOP: tx=1 for STOP_BITS bit times. On the final bit end: state=IDLE and uart_busy=0. tx_done=1 in that same cycle, for one cycle only.
- Every output changes exactly on the bit-time boundaries above.
- Frame length: (1+8+P+STOP_BITS)*CLKS_PER_BIT cycles from the first START cycle, where P is 0 or 1. Default is 10*434 = 4340 cycles.
- Back-to-back: tx_start asserted in the first cycle with uart_busy=0 is accepted. There is exactly 1 idle-high clock between frames.
- The shift register is only loaded on acceptance. Changing tx_data mid-frame has no effect.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP, and a parameter PARITY_ODD (default 0).
  - The parity bit is the XOR of the latched byte, inverted when PARITY_ODD=1.
  - The parity bit is transmitted for one bit time, so frames are 11 bits with STOP_BITS=1.
- Not defined: no PARITY state and no PARITY_ODD parameter; frame is 8N1 or 8N2.

Decomposition:
- Package uart_pkg holds:
  - the tx state encoding localparams (IDLE, START, DATA, PARITY, STOP);
  - the default CLOCK_FREQ and BAUD_RATE constants;
  - a bit-count helper for counter width, $clog2(CLKS_PER_BIT).
- One sub-module, uart_baud_tick. It holds the baud counter with enable and clear, and outputs a bit_end pulse. It is reusable by a future uart_receiver.

Test Plan:
- Reset check: bench uses CLOCK_FREQ=16, BAUD_RATE=1 (CLKS_PER_BIT=16). Hold reset=0 with random tx_start. Required: tx=1, uart_busy=0, tx_done=0 throughout.
- Single byte 0xA5: pulse tx_start. Required:
  - uart_busy=1 the next cycle;
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles;
  - tx_done pulses at cycle 160, with uart_busy falling in the same cycle.
- Busy ignore: send 0x3C, then pulse tx_start with 0xFF at mid-frame cycle 50. Required: only 0x3C appears on the line, and exactly one tx_done.
- Back-to-back: send 0x00, then pulse tx_start with 0xFF in the first cycle uart_busy=0. Required:
  - second START begins after exactly 1 idle-high cycle;
  - data bits all 1;
  - two tx_done pulses 161 cycles apart.
- Reset mid-frame: assert reset=0 at cycle 70 of a 0x55 frame. Required: tx=1 and uart_busy=0 immediately. Then send 0x81 and check the full 0x81 frame is correct.
- Parity (UART_TX_PARITY_EN, PARITY_ODD=0): send 0x07. Required: parity bit 1 after the data bits, then the stop bit, with the 11-bit frame ending at cycle 176.
